// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word, cache line and the cache arbiter state encoding.
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } lc3b_arb_state;
endpackage

// File: rtl/cache_arbiter.sv
// Shares one physical memory port between I-cache and D-cache with alternating fairness.
// Grant costs one cycle; owner's resp follows pmem_resp combinationally; always one IDLE cycle between jobs.
module cache_arbiter
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           icache_pmem_read,
  input  lc3b_word       icache_pmem_address,
  output lc3b_cache_line icache_pmem_rdata,
  output logic           icache_pmem_resp,
  input  logic           dcache_pmem_read,
  input  logic           dcache_pmem_write,
  input  lc3b_word       dcache_pmem_address,
  input  lc3b_cache_line dcache_pmem_wdata,
  output lc3b_cache_line dcache_pmem_rdata,
  output logic           dcache_pmem_resp,
  output logic           pmem_read,
  output logic           pmem_write,
  output lc3b_word       pmem_address,
  output lc3b_cache_line pmem_wdata,
  input  lc3b_cache_line pmem_rdata,
  input  logic           pmem_resp
);

  lc3b_arb_state  r_state;
  lc3b_arb_state  w_next_state;
  logic           r_last_grant_d;
  lc3b_word       r_addr;
  lc3b_cache_line r_wdata;
  logic           r_op_read;
  logic           r_op_write;
  logic           w_i_pend;
  logic           w_d_pend;
  logic           w_start;
  logic           w_done;

  assign w_i_pend = icache_pmem_read;
  assign w_d_pend = dcache_pmem_read | dcache_pmem_write;
  assign w_start  = (r_state == IDLE) && (w_next_state != IDLE);
  assign w_done   = (r_state != IDLE) && pmem_resp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // On a tie, the requester that did not win last time gets the port.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_i_pend && w_d_pend) w_next_state = r_last_grant_d ? SERVE_I : SERVE_D;
        else if (w_i_pend)        w_next_state = SERVE_I;
        else if (w_d_pend)        w_next_state = SERVE_D;
        else                      w_next_state = IDLE;
      end
      SERVE_I: if (pmem_resp) w_next_state = IDLE;
      SERVE_D: if (pmem_resp) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    pmem_read        = (r_state != IDLE) && r_op_read;
    pmem_write       = (r_state != IDLE) && r_op_write;
    icache_pmem_resp = (r_state == SERVE_I) && pmem_resp;
    dcache_pmem_resp = (r_state == SERVE_D) && pmem_resp;
  end

  // A simultaneous D read+write is treated as a write-back only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant_d <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_op_read      <= 1'b0;
      r_op_write     <= 1'b0;
    end else begin
      if (w_start) begin
        if (w_next_state == SERVE_D) begin
          r_addr     <= dcache_pmem_address;
          r_wdata    <= dcache_pmem_wdata;
          r_op_write <= dcache_pmem_write;
          r_op_read  <= dcache_pmem_read & ~dcache_pmem_write;
        end else begin
          r_addr     <= icache_pmem_address;
          r_op_write <= 1'b0;
          r_op_read  <= 1'b1;
        end
      end
      if (w_done) r_last_grant_d <= (r_state == SERVE_D);
    end
  end

  assign pmem_address      = r_addr;
  assign pmem_wdata        = r_wdata;
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: grant timing, fairness, latching, spurious resp and mid-job reset.
module tb_cache_arbiter;
  logic         clk;
  logic         reset;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic [127:0] icache_pmem_rdata;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic [127:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_checks;
  int n_fail;

  cache_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    icache_pmem_read    = 1'b0;
    icache_pmem_address = 16'h0;
    dcache_pmem_read    = 1'b0;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = 16'h0;
    dcache_pmem_wdata   = '0;
    pmem_rdata          = '0;
    pmem_resp           = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp});
    end
    n_checks++;
    if (pmem_address !== 16'h0 || pmem_wdata !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h want 0", pmem_address, pmem_wdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_i_read();
    logic [127:0] line;
    line = {4{32'hCAFE_0123}};
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1230;
    n_checks++;
    if (pmem_read !== 1'b0) begin
      n_fail++; $display("FAIL i_read_no_early_strobe: got %b want 0", pmem_read);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h1230) begin
        n_fail++;
        $display("FAIL i_read_strobe: rd %b wr %b addr %h want 1 0 1230", pmem_read, pmem_write, pmem_address);
      end
      tick();
    end
    pmem_resp  = 1'b1;
    pmem_rdata = line;
    icache_pmem_read = 1'b0;
    #1;
    n_checks++;
    if (icache_pmem_resp !== 1'b1 || dcache_pmem_resp !== 1'b0) begin
      n_fail++; $display("FAIL i_read_resp: i %b d %b want 1 0", icache_pmem_resp, dcache_pmem_resp);
    end
    n_checks++;
    if (icache_pmem_rdata !== line || dcache_pmem_rdata !== line) begin
      n_fail++; $display("FAIL i_read_rdata: i %h d %h want %h", icache_pmem_rdata, dcache_pmem_rdata, line);
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    n_checks++;
    if (pmem_read !== 1'b0 || icache_pmem_resp !== 1'b0) begin
      n_fail++; $display("FAIL i_read_idle_after: rd %b resp %b want 0 0", pmem_read, icache_pmem_resp);
    end
  endtask

  task automatic test_fairness();
    logic [15:0] exp_addr;
    logic        exp_d;
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1111;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      exp_d    = (k % 2 == 0);
      exp_addr = exp_d ? 16'h2222 : 16'h1111;
      tick();
      n_checks++;
      if (pmem_read !== 1'b1 || pmem_address !== exp_addr) begin
        n_fail++; $display("FAIL fair_grant_%0d: rd %b addr %h want 1 %h", k, pmem_read, pmem_address, exp_addr);
      end
      pmem_resp = 1'b1;
      #1;
      n_checks++;
      if (dcache_pmem_resp !== exp_d || icache_pmem_resp !== ~exp_d) begin
        n_fail++;
        $display("FAIL fair_resp_%0d: d %b i %b want %b %b", k, dcache_pmem_resp, icache_pmem_resp, exp_d, ~exp_d);
      end
      tick();
      pmem_resp = 1'b0;
      #1;
      n_checks++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
        n_fail++; $display("FAIL fair_idle_gap_%0d: rd %b wr %b want 0 0", k, pmem_read, pmem_write);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_d_write();
    logic [127:0] wline;
    wline = {16{8'hA5}};
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h4000;
    dcache_pmem_wdata   = wline;
    tick();
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = 16'hFFFF;
    dcache_pmem_wdata   = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h4000 || pmem_wdata !== wline) begin
        n_fail++;
        $display("FAIL d_write_hold_%0d: wr %b rd %b addr %h wdata %h want 1 0 4000 %h",
                 c, pmem_write, pmem_read, pmem_address, pmem_wdata, wline);
      end
      if (c < 2) tick();
    end
    pmem_resp = 1'b1;
    #1;
    n_checks++;
    if (dcache_pmem_resp !== 1'b1 || icache_pmem_resp !== 1'b0) begin
      n_fail++; $display("FAIL d_write_resp: d %b i %b want 1 0", dcache_pmem_resp, icache_pmem_resp);
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    n_checks++;
    if (pmem_write !== 1'b0) begin
      n_fail++; $display("FAIL d_write_idle_after: wr %b want 0", pmem_write);
    end
  endtask

  task automatic test_spurious();
    clear_inputs();
    pmem_resp = 1'b1;
    #1;
    n_checks++;
    if (icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0) begin
      n_fail++; $display("FAIL spurious_resp: i %b d %b want 0 0", icache_pmem_resp, dcache_pmem_resp);
    end
    tick();
    n_checks++;
    if ({pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0000) begin
      n_fail++;
      $display("FAIL spurious_stays_idle: got %b want 0000",
               {pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp});
    end
    pmem_resp = 1'b0;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h0ABC;
    dcache_pmem_wdata   = {8{16'h5A3C}};
    tick();
    dcache_pmem_read  = 1'b0;
    dcache_pmem_write = 1'b0;
    #1;
    n_checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h0ABC) begin
      n_fail++; $display("FAIL rw_is_write: wr %b rd %b addr %h want 1 0 0abc", pmem_write, pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h7000;
    dcache_pmem_wdata   = {4{32'h1234_5678}};
    tick();
    n_checks++;
    if (pmem_write !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_started: wr %b want 1", pmem_write);
    end
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h3330;
    pmem_resp = 1'b1;
    reset     = 1'b1;
    #1;
    n_checks++;
    if ({pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0000 ||
        pmem_address !== 16'h0 || pmem_wdata !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: ctrl %b addr %h wdata %h want 0000 0 0",
               {pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp}, pmem_address, pmem_wdata);
    end
    pmem_resp = 1'b0;
    dcache_pmem_write = 1'b0;
    #1;
    reset = 1'b0;
    tick();
    n_checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h3330) begin
      n_fail++; $display("FAIL reset_mid_i_first: rd %b wr %b addr %h want 1 0 3330", pmem_read, pmem_write, pmem_address);
    end
    icache_pmem_read = 1'b0;
    pmem_resp = 1'b1;
    #1;
    n_checks++;
    if (icache_pmem_resp !== 1'b1 || dcache_pmem_resp !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_i_resp: i %b d %b want 1 0", icache_pmem_resp, dcache_pmem_resp);
    end
    tick();
    pmem_resp = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_inputs();
    test_reset();
    test_i_read();
    test_fairness();
    test_d_write();
    test_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL come from shared types: address lc3b_word (16 bits), line lc3b_cache_line (128 bits).
REQ-002 The block SHALL use one clock, clk, with reset asynchronous and active-high on port reset; it SHALL expose the following ports:
  clk  in  1  sole clock, all state on rising edge
  reset  in  1  asynchronous active-high reset
  icache_pmem_read  in  1  I-cache line-fill request
  icache_pmem_address  in  16  I-cache line address
  icache_pmem_rdata  out  128  line returned to I-cache
  icache_pmem_resp  out  1  I-cache transaction complete
  dcache_pmem_read  in  1  D-cache line-fill request
  dcache_pmem_write  in  1  D-cache write-back request
  dcache_pmem_address  in  16  D-cache line address
  dcache_pmem_wdata  in  128  D-cache write-back line
  dcache_pmem_rdata  out  128  line returned to D-cache
  dcache_pmem_resp  out  1  D-cache transaction complete
  pmem_read  out  1  physical memory read strobe
  pmem_write  out  1  physical memory write strobe
  pmem_address  out  16  physical memory address
  pmem_wdata  out  128  physical memory write line
  pmem_rdata  in  128  physical memory read line
  pmem_resp  in  1  physical memory transaction complete

Function
REQ-003 The FSM SHALL have exactly 3 states: IDLE, SERVE_I, SERVE_D.
REQ-004 IDLE, I pending only (icache_pmem_read=1) SHALL -> SERVE_I next edge; D pending only (dcache read|write=1) SHALL -> SERVE_D.
REQ-005 IDLE, both pending, SHALL grant the requester not granted last (last_grant register); a tie immediately after reset SHALL go to D.
REQ-006 On every IDLE->SERVE_x transition the block SHALL latch the winner's address, wdata (D only) and op into internal registers; pmem_address/pmem_wdata SHALL be driven only from these registers.
REQ-007 In SERVE_x, pmem_read/pmem_write SHALL be asserted from latched op (Moore outputs); first strobe cycle SHALL be the cycle after the request was sampled in IDLE.
REQ-008 dcache read and write both asserted SHALL be latched as a write only.
REQ-009 In SERVE_x with pmem_resp=1, the block SHALL assert x_pmem_resp in that same cycle (combinational) and SHALL return to IDLE next edge, updating last_grant=x.
REQ-010 icache_pmem_rdata and dcache_pmem_rdata SHALL both equal pmem_rdata at all times; only resp SHALL be gated.
REQ-011 The non-owner's resp SHALL be 0 always, and the block SHALL never assert a resp outside SERVE_x with pmem_resp=1.
REQ-012 pmem_resp in IDLE SHALL be ignored.
REQ-013 Once granted, a transaction SHALL run until pmem_resp even if the owner deasserts its request; changes to requester inputs mid-transaction SHALL NOT affect pmem outputs.
REQ-014 Every transaction SHALL be followed by at least one IDLE cycle with pmem_read=pmem_write=0, and back-to-back pending requests SHALL alternate I/D.
REQ-015 Transaction latency SHALL be 1 cycle grant + N pmem cycles, with resp in the same cycle as pmem_resp.

Reset
REQ-016 Asserting reset, including mid-transaction, SHALL force state=IDLE, last_grant=I, latched address/wdata/op=0, and all resp/strobe outputs to 0 immediately; the abandoned transaction SHALL not be resumed.

Structure
REQ-017 An enum lc3b_arb_state {IDLE, SERVE_I, SERVE_D} SHALL be added to lc3b_types, reusing lc3b_word and lc3b_cache_line there.
REQ-018 The block SHALL be a single module with no sub-module; all FSM, latch and fairness logic SHALL be local.

Verification
REQ-019 I read addr 0x1230 alone, pmem_resp after 3 cycles -> pmem_read=1 at cycle+1, pmem_address=0x1230, icache_pmem_resp=1 with pmem_rdata, dcache_pmem_resp=0.
REQ-020 I and D reads both pending from reset, held -> order D, I, D, I with one IDLE cycle between each.
REQ-021 D write addr 0x4000 wdata 0xA5..A5, inputs changed to 0xFFFF/0 after grant -> pmem_write=1, pmem_address=0x4000, pmem_wdata=0xA5..A5 held until resp.
REQ-022 Spurious pmem_resp in IDLE, and dcache read+write together -> no resp asserted; the latter performs a write only.
REQ-023 reset pulsed during SERVE_D -> outputs 0 at once; after release, pending I request is granted first.
